triangle_scan_gen: RTL and testbench

//  Upstream source of the rasterizer's pixel stream. Accepts one triangle
//  (3 signed vertices) and computes its screen-clamped bounding box. Emits

---
 rtl/triangle_scan_gen_if.sv | 25 ++
 rtl/triangle_scan_gen.sv | 150 +++++++++++++++
 tb/tb_triangle_scan_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_scan_gen_if.sv
// Triangle-in / pixel-out stream bundle for triangle_scan_gen.
// The slave modport is the generator's view; the master modport is its driver/consumer's view.
interface triangle_scan_gen_if;
  logic               triValid;
  logic               triReady;
  logic signed [10:0] V1_x, V1_y, V2_x, V2_y, V3_x, V3_y;
  logic               outValid;
  logic               outReady;
  logic        [10:0] pixel_x, pixel_y;
  logic signed [10:0] Vo1_x, Vo1_y, Vo2_x, Vo2_y, Vo3_x, Vo3_y;
  logic               busy;
  logic               done;

  modport slave (
    input  triValid, V1_x, V1_y, V2_x, V2_y, V3_x, V3_y, outReady,
    output triReady, outValid, pixel_x, pixel_y,
           Vo1_x, Vo1_y, Vo2_x, Vo2_y, Vo3_x, Vo3_y, busy, done
  );

  modport master (
    output triValid, V1_x, V1_y, V2_x, V2_y, V3_x, V3_y, outReady,
    input  triReady, outValid, pixel_x, pixel_y,
           Vo1_x, Vo1_y, Vo2_x, Vo2_y, Vo3_x, Vo3_y, busy, done
  );
endinterface

// File: rtl/triangle_scan_gen.sv
// Latches a triangle, computes its screen-clamped bounding box and streams every box pixel row-major.
// Optional macro BACKFACE_CULL_EN: triangles with non-positive signed area emit no pixels.
module triangle_scan_gen #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  triangle_scan_gen_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SCAN, ST_DONE} state_t;

  localparam logic signed [10:0] XMAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] YMAX = 11'(SCREEN_H - 1);
  localparam logic signed [10:0] ZERO = '0;

  state_t             r_state, w_state_next;
  logic signed [10:0] w_in_x [3];
  logic signed [10:0] w_in_y [3];
  logic signed [10:0] r_vx [3];
  logic signed [10:0] r_vy [3];
  logic        [10:0] r_minx, r_maxx, r_maxy;
  logic        [10:0] r_cur_x, r_cur_y;

  logic               w_tri_ready, w_accept, w_hs, w_last;
  logic signed [10:0] w_raw_minx, w_raw_maxx, w_raw_miny, w_raw_maxy;
  logic        [10:0] w_minx_c, w_maxx_c, w_miny_c, w_maxy_c;
  logic               w_empty, w_culled, w_skip;

  function automatic logic signed [10:0] min3(input logic signed [10:0] a, b, c);
    logic signed [10:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [10:0] max3(input logic signed [10:0] a, b, c);
    logic signed [10:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign w_in_x[0] = bus.V1_x;
  assign w_in_x[1] = bus.V2_x;
  assign w_in_x[2] = bus.V3_x;
  assign w_in_y[0] = bus.V1_y;
  assign w_in_y[1] = bus.V2_y;
  assign w_in_y[2] = bus.V3_y;

  // triReady is gated by rst_n so it reads low for the whole reset pulse
  assign w_tri_ready = (r_state == ST_IDLE) && rst_n;
  assign w_accept    = bus.triValid && w_tri_ready;
  assign w_hs        = (r_state == ST_SCAN) && bus.outReady;
  assign w_last      = (r_cur_x == r_maxx) && (r_cur_y == r_maxy);

  assign w_raw_minx = min3(r_vx[0], r_vx[1], r_vx[2]);
  assign w_raw_maxx = max3(r_vx[0], r_vx[1], r_vx[2]);
  assign w_raw_miny = min3(r_vy[0], r_vy[1], r_vy[2]);
  assign w_raw_maxy = max3(r_vy[0], r_vy[1], r_vy[2]);

  assign w_minx_c = (w_raw_minx < ZERO) ? 11'd0 : w_raw_minx;
  assign w_miny_c = (w_raw_miny < ZERO) ? 11'd0 : w_raw_miny;
  assign w_maxx_c = (w_raw_maxx > XMAX) ? XMAX : w_raw_maxx;
  assign w_maxy_c = (w_raw_maxy > YMAX) ? YMAX : w_raw_maxy;

  assign w_empty = (w_raw_maxx < ZERO) || (w_raw_minx > XMAX) ||
                   (w_raw_maxy < ZERO) || (w_raw_miny > YMAX);

`ifdef BACKFACE_CULL_EN
  logic signed [11:0] w_e1x, w_e1y, w_e2x, w_e2y;
  logic signed [23:0] w_area2;
  assign w_e1x   = $signed({r_vx[1][10], r_vx[1]}) - $signed({r_vx[0][10], r_vx[0]});
  assign w_e1y   = $signed({r_vy[1][10], r_vy[1]}) - $signed({r_vy[0][10], r_vy[0]});
  assign w_e2x   = $signed({r_vx[2][10], r_vx[2]}) - $signed({r_vx[0][10], r_vx[0]});
  assign w_e2y   = $signed({r_vy[2][10], r_vy[2]}) - $signed({r_vy[0][10], r_vy[0]});
  assign w_area2 = (24'(w_e1x) * 24'(w_e2y)) - (24'(w_e1y) * 24'(w_e2x));
  assign w_culled = (w_area2 <= 24'sd0);
`else
  assign w_culled = 1'b0;
`endif

  assign w_skip = w_empty || w_culled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_SETUP;
      ST_SETUP: w_state_next = w_skip ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (w_hs && w_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
      end
      r_minx  <= '0;
      r_maxx  <= '0;
      r_maxy  <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < 3; i++) begin
          r_vx[i] <= w_in_x[i];
          r_vy[i] <= w_in_y[i];
        end
      end
      if (r_state == ST_SETUP && !w_skip) begin
        r_minx  <= w_minx_c;
        r_maxx  <= w_maxx_c;
        r_maxy  <= w_maxy_c;
        r_cur_x <= w_minx_c;
        r_cur_y <= w_miny_c;
      end
      // On the final pixel the cursor is left as-is; the state change ends the stream
      if (w_hs) begin
        if (r_cur_x != r_maxx) begin
          r_cur_x <= r_cur_x + 11'd1;
        end else if (r_cur_y != r_maxy) begin
          r_cur_x <= r_minx;
          r_cur_y <= r_cur_y + 11'd1;
        end
      end
    end
  end

  assign bus.triReady = w_tri_ready;
  assign bus.outValid = (r_state == ST_SCAN);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.pixel_x  = r_cur_x;
  assign bus.pixel_y  = r_cur_y;
  assign bus.Vo1_x    = r_vx[0];
  assign bus.Vo1_y    = r_vy[0];
  assign bus.Vo2_x    = r_vx[1];
  assign bus.Vo2_y    = r_vy[1];
  assign bus.Vo3_x    = r_vx[2];
  assign bus.Vo3_y    = r_vy[2];

endmodule

// File: tb/tb_triangle_scan_gen.sv
// Scoreboard bench for triangle_scan_gen: directed and random triangles against a bounding-box model.
module tb_triangle_scan_gen;
  localparam int W = 640;
  localparam int H = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  triangle_scan_gen_if bus();

  triangle_scan_gen #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int x; int y;} pix_t;
  pix_t exp_q[$];
  int   exp_v[6];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0, last_hs_cyc = 0;
  int   hs_count = 0, done_seen = 0, done_exp = 0;
  int   rdy_mode = 0;
  bit   tri_empty = 1'b0, first_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.outReady = 1'b1;
      1:       bus.outReady = ~bus.outReady;
      default: bus.outReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every presented pixel against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.outValid) begin
        chk("busy_in_scan", bus.busy, 1);
        if (first_pending) begin
          chk("first_pixel_latency", cyc, accept_cyc + 2);
          first_pending = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got (%0d,%0d), expected no pixel", bus.pixel_x, bus.pixel_y);
        end else begin
          chk("pixel_x", bus.pixel_x, exp_q[0].x);
          chk("pixel_y", bus.pixel_y, exp_q[0].y);
          chk("Vo1_x", bus.Vo1_x, exp_v[0]);
          chk("Vo1_y", bus.Vo1_y, exp_v[1]);
          chk("Vo2_x", bus.Vo2_x, exp_v[2]);
          chk("Vo2_y", bus.Vo2_y, exp_v[3]);
          chk("Vo3_x", bus.Vo3_x, exp_v[4]);
          chk("Vo3_y", bus.Vo3_y, exp_v[5]);
          if (bus.outReady) begin
            void'(exp_q.pop_front());
            hs_count++;
            last_hs_cyc = cyc;
          end
        end
      end
      if (bus.done) begin
        done_seen++;
        chk("done_latency", cyc, tri_empty ? accept_cyc + 2 : last_hs_cyc + 1);
        chk("pixels_left_at_done", exp_q.size(), 0);
        chk("outvalid_in_done", bus.outValid, 0);
      end
    end
  end

  // Reference: clamped bounding box (plus optional cull), expanded row-major
  task automatic issue_tri(input int x1, y1, x2, y2, x3, y3);
    int n, minx, maxx, miny, maxy, area2;
    bit empty;
    n = 0;
    while (!bus.triReady && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.triReady) begin
      checks++;
      errors++;
      $display("FAIL triready_timeout: got 0, expected 1 within 5000 cycles");
      return;
    end
    minx = (x1 < x2) ? ((x1 < x3) ? x1 : x3) : ((x2 < x3) ? x2 : x3);
    maxx = (x1 > x2) ? ((x1 > x3) ? x1 : x3) : ((x2 > x3) ? x2 : x3);
    miny = (y1 < y2) ? ((y1 < y3) ? y1 : y3) : ((y2 < y3) ? y2 : y3);
    maxy = (y1 > y2) ? ((y1 > y3) ? y1 : y3) : ((y2 > y3) ? y2 : y3);
    empty = (maxx < 0) || (minx > W - 1) || (maxy < 0) || (miny > H - 1);
    area2 = (x2 - x1) * (y3 - y1) - (y2 - y1) * (x3 - x1);
`ifdef BACKFACE_CULL_EN
    if (area2 <= 0) empty = 1'b1;
`endif
    if (!empty) begin
      if (minx < 0) minx = 0;
      if (miny < 0) miny = 0;
      if (maxx > W - 1) maxx = W - 1;
      if (maxy > H - 1) maxy = H - 1;
      for (int y = miny; y <= maxy; y++)
        for (int x = minx; x <= maxx; x++)
          exp_q.push_back('{x, y});
    end
    $display("tri (%0d,%0d) (%0d,%0d) (%0d,%0d) area2=%0d -> %0d pixels",
             x1, y1, x2, y2, x3, y3, area2, exp_q.size());
    exp_v = '{x1, y1, x2, y2, x3, y3};
    tri_empty     = empty;
    first_pending = !empty;
    accept_cyc    = cyc;
    done_exp++;
    bus.V1_x = 11'(x1); bus.V1_y = 11'(y1);
    bus.V2_x = 11'(x2); bus.V2_y = 11'(y2);
    bus.V3_x = 11'(x3); bus.V3_y = 11'(y3);
    bus.triValid = 1'b1;
    @(negedge clk);
  endtask

  // Waits for the done pulse; with junk set, triValid stays high with garbage until then
  task automatic finish_tri(input bit junk);
    int n;
    n = 0;
    if (junk) begin
      while (!bus.done && n < 5000) begin
        bus.V1_x = 11'($urandom); bus.V2_y = 11'($urandom); bus.V3_x = 11'($urandom);
        @(negedge clk);
        n++;
      end
    end
    bus.triValid = 1'b0;
    n = 0;
    while (done_seen < done_exp && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_count", done_seen, done_exp);
    if (junk) begin
      @(negedge clk);
      chk("no_accept_while_busy", bus.busy, 0);
      chk("triready_after_done", bus.triReady, 1);
    end
  endtask

  task automatic run_tri(input int x1, y1, x2, y2, x3, y3);
    issue_tri(x1, y1, x2, y2, x3, y3);
    finish_tri(1'b0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, x1, y1;
    bus.triValid = 1'b0;
    bus.outReady = 1'b0;
    bus.V1_x = '0; bus.V1_y = '0; bus.V2_x = '0;
    bus.V2_y = '0; bus.V3_x = '0; bus.V3_y = '0;

    #2;
    chk("reset_triready", bus.triReady, 0);
    chk("reset_outvalid", bus.outValid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_pixel_x", bus.pixel_x, 0);
    chk("reset_Vo3_y", bus.Vo3_y, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_triready", bus.triReady, 1);
    @(negedge clk);

    rdy_mode = 0;
    run_tri(10, 10, 13, 10, 10, 12);
    rdy_mode = 1;
    issue_tri(10, 10, 13, 10, 10, 12);
    finish_tri(1'b1);
    rdy_mode = 0;
    run_tri(-3, -3, 2, -3, -3, 2);
    run_tri(-20, -20, -5, -20, -20, -5);
    run_tri(5, 5, 5, 5, 5, 5);
    run_tri(10, 10, 10, 12, 13, 10);
    run_tri(635, 475, 645, 476, 636, 490);

    // Reset in the middle of a scan
    base = hs_count;
    issue_tri(10, 10, 13, 10, 10, 12);
    n = 0;
    while (hs_count < base + 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outvalid", bus.outValid, 0);
    chk("midreset_triready", bus.triReady, 0);
    chk("midreset_busy", bus.busy, 0);
    exp_q.delete();
    first_pending = 1'b0;
    done_exp--;
    bus.triValid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midreset_done", bus.done, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("postreset_triready", bus.triReady, 1);
    @(negedge clk);
    run_tri(20, 30, 22, 30, 20, 31);

    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      if (t % 6 == 5) begin
        x1 = int'($urandom_range(0, 1200)) - 600;
        y1 = int'($urandom_range(0, 1200)) - 600;
      end else begin
        x1 = int'($urandom_range(0, 719)) - 40;
        y1 = int'($urandom_range(0, 559)) - 40;
      end
      issue_tri(x1, y1,
                x1 + int'($urandom_range(0, 16)) - 8, y1 + int'($urandom_range(0, 16)) - 8,
                x1 + int'($urandom_range(0, 16)) - 8, y1 + int'($urandom_range(0, 16)) - 8);
      finish_tri(t % 4 == 0);
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_done_count", done_seen, done_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
